// File: rtl/clk_divider.sv
// clk_divider: free-running counter divides CLK into a 50%-duty CLK_OUT of period 2*HALF_PERIOD.
// Optional macro CLK_DIV_TICK_EN adds TICK, a one-cycle strobe on each CLK_OUT rise.
`default_nettype none

module clk_divider #(
  parameter int HALF_PERIOD = 25000
) (
  input  logic CLK,
  input  logic RESET_N,
  output logic CLK_OUT
`ifdef CLK_DIV_TICK_EN
  ,
  output logic TICK
`endif
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CNT_W-1:0] cnt;
  logic             terminal;

  // Anything at or above the last count wraps, so a corrupted counter recovers in one pass.
  assign terminal = (int'(cnt) >= (HALF_PERIOD - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt     <= '0;
      CLK_OUT <= 1'b0;
    end else if (terminal) begin
      cnt     <= '0;
      CLK_OUT <= ~CLK_OUT;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

`ifdef CLK_DIV_TICK_EN
  // Set on the same edge that takes CLK_OUT from 0 to 1.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      TICK <= 1'b0;
    end else begin
      TICK <= terminal & ~CLK_OUT;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_divider.sv
// tb_clk_divider: directed checks of clk_divider over several HALF_PERIOD values.
`default_nettype none

module tb_clk_divider;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic o4, o1, o5, o3, obig;
`ifdef CLK_DIV_TICK_EN
  logic t4, t1, t5, t3, tbig;
`endif

  int total = 0;
  int bad   = 0;

  clk_divider #(.HALF_PERIOD(4)) u_hp4 (
    .CLK(clk), .RESET_N(rst_n), .CLK_OUT(o4)
`ifdef CLK_DIV_TICK_EN
    , .TICK(t4)
`endif
  );

  clk_divider #(.HALF_PERIOD(1)) u_hp1 (
    .CLK(clk), .RESET_N(rst_n), .CLK_OUT(o1)
`ifdef CLK_DIV_TICK_EN
    , .TICK(t1)
`endif
  );

  clk_divider #(.HALF_PERIOD(5)) u_hp5 (
    .CLK(clk), .RESET_N(rst_n), .CLK_OUT(o5)
`ifdef CLK_DIV_TICK_EN
    , .TICK(t5)
`endif
  );

  clk_divider #(.HALF_PERIOD(3)) u_hp3 (
    .CLK(clk), .RESET_N(rst_n), .CLK_OUT(o3)
`ifdef CLK_DIV_TICK_EN
    , .TICK(t3)
`endif
  );

  clk_divider u_default (
    .CLK(clk), .RESET_N(rst_n), .CLK_OUT(obig)
`ifdef CLK_DIV_TICK_EN
    , .TICK(tbig)
`endif
  );

  // One rising edge, then settle to the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset between edges, hold it, and return on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({o4, o1, o5, o3, obig} !== 5'b0) begin
        bad++;
        $display("FAIL reset_outputs: got %b want 00000", {o4, o1, o5, o3, obig});
      end
`ifdef CLK_DIV_TICK_EN
      total++;
      if ({t4, t1, t5, t3, tbig} !== 5'b0) begin
        bad++;
        $display("FAIL reset_tick: got %b want 00000", {t4, t1, t5, t3, tbig});
      end
`endif
    end
  endtask

  task automatic test_first_rise();
    logic e;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      e = ((k / 4) % 2) == 1;
      total++;
      if (o4 !== e) begin
        bad++;
        $display("FAIL first_rise_hp4 edge %0d: got %b want %b", k, o4, e);
      end
    end
  endtask

  task automatic test_duty();
    logic e;
    logic prev;
    int   run;
    bit   seen;
    apply_reset();
    rst_n = 1'b1;
    prev  = 1'b0;
    run   = 0;
    seen  = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      e = ((k / 4) % 2) == 1;
      total++;
      if (o4 !== e) begin
        bad++;
        $display("FAIL duty_wave_hp4 edge %0d: got %b want %b", k, o4, e);
      end
      if (o4 !== prev) begin
        if (seen) begin
          total++;
          if (run != 4) begin
            bad++;
            $display("FAIL duty_phase_hp4 edge %0d: phase length %0d want 4", k, run);
          end
        end
        seen = 1;
        run  = 1;
        prev = o4;
      end else begin
        run++;
      end
    end
  endtask

  task automatic test_half_one();
    logic e;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      e = (k % 2) == 1;
      total++;
      if (o1 !== e) begin
        bad++;
        $display("FAIL toggle_hp1 edge %0d: got %b want %b", k, o1, e);
      end
    end
  endtask

  task automatic test_async_mid();
    logic e;
    apply_reset();
    rst_n = 1'b1;
    repeat (6) step();
    total++;
    if (o5 !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre_hp5: got %b want 1", o5);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o5 !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async_hp5: got %b want 0", o5);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      e = ((k / 5) % 2) == 1;
      total++;
      if (o5 !== e) begin
        bad++;
        $display("FAIL midreset_restart_hp5 edge %0d: got %b want %b", k, o5, e);
      end
    end
  endtask

  task automatic test_tick();
    logic e;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      e = ((k / 3) % 2) == 1;
      total++;
      if (o3 !== e) begin
        bad++;
        $display("FAIL wave_hp3 edge %0d: got %b want %b", k, o3, e);
      end
`ifdef CLK_DIV_TICK_EN
      e = ((k % 3) == 0) && (((k / 3) % 2) == 1);
      total++;
      if (t3 !== e) begin
        bad++;
        $display("FAIL tick_hp3 edge %0d: got %b want %b", k, t3, e);
      end
`endif
    end
  endtask

  task automatic test_default();
    int k;
    apply_reset();
    rst_n = 1'b1;
    k = 0;
    while (obig == 1'b0 && k < 30000) begin
      step();
      k++;
    end
    total++;
    if (k != 25000) begin
      bad++;
      $display("FAIL default_rise: rise at edge %0d want 25000", k);
    end
    while (obig == 1'b1 && k < 60000) begin
      step();
      k++;
    end
    total++;
    if (k != 50000) begin
      bad++;
      $display("FAIL default_fall: fall at edge %0d want 50000", k);
    end
  endtask

  initial begin
    test_reset();
    test_first_rise();
    test_duty();
    test_half_one();
    test_async_mid();
    test_tick();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
